// File: rtl/dac_serializer.sv
// Codec DAC serializer: FIFO-buffered stereo pairs shifted MSB-first onto AUD_DACDAT.
// Define DAC_SERIALIZER_I2S_MODE_EN for I2S (one-BCLK delayed) timing; default is left-justified.
module dac_serializer #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write,
    input  logic [DATA_W-1:0]             writedata_left,
    input  logic [DATA_W-1:0]             writedata_right,
    output logic                          write_ready,
    input  logic                          aud_bclk,
    input  logic                          aud_daclrck,
    output logic                          aud_dacdat,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            bclkSync_q, lrckSync_q;
    logic                  bclkHist_q;
    logic                  lrck_q, lrck_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [2*DATA_W-1:0]   fifoMem [FIFO_DEPTH];
    logic [2*DATA_W-1:0]   headEntry;
    logic [DATA_W-1:0]     shift_q, shift_d, holdRight_q, holdRight_d;
    logic [BIT_W-1:0]      bitCnt_q, bitCnt_d;
    logic                  dacdat_q, dacdat_d, underflow_q, underflow_d;
    logic                  bclkFall, lrckSample, lrckEdge, frameStart, rightStart;
    logic                  push, pop, startLoad;
    logic [DATA_W-1:0]     loadWord;

    // lrck_q holds the previous bclk-fall sample, so an edge is flagged on the same fall pulse
    assign bclkFall    = bclkHist_q & ~bclkSync_q[1];
    assign lrckSample  = lrckSync_q[1];
    assign lrckEdge    = bclkFall && (lrckSample != lrck_q);
    assign frameStart  = lrckEdge && !lrckSample;
    assign rightStart  = lrckEdge && lrckSample;
    assign write_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push        = write && write_ready;
    assign headEntry   = fifoMem[rdPtr_q];

    assign aud_dacdat  = dacdat_q;
    assign underflow   = underflow_q;
    assign fifo_count  = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclkSync_q <= '0;
            lrckSync_q <= '0;
            bclkHist_q <= 1'b0;
        end else begin
            bclkSync_q <= {bclkSync_q[0], aud_bclk};
            lrckSync_q <= {lrckSync_q[0], aud_daclrck};
            bclkHist_q <= bclkSync_q[1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr_q] <= {writedata_left, writedata_right};
        end
    end

    always_comb begin
        state_d     = state_q;
        lrck_d      = lrck_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        shift_d     = shift_q;
        holdRight_d = holdRight_q;
        bitCnt_d    = bitCnt_q;
        dacdat_d    = dacdat_q;
        underflow_d = underflow_q;
        pop         = 1'b0;
        startLoad   = 1'b0;
        loadWord    = '0;

        if (bclkFall) begin
            lrck_d = lrckSample;
        end
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end

        if (state_q == IDLE) begin
            dacdat_d = 1'b0;
            if (frameStart) begin
                state_d = ACTIVE;
            end
        end

        // The edge that leaves IDLE is itself a frame start, avoiding a half frame
        if (frameStart) begin
            startLoad = 1'b1;
            if (count_q != '0) begin
                pop         = 1'b1;
                loadWord    = headEntry[2*DATA_W-1:DATA_W];
                holdRight_d = headEntry[DATA_W-1:0];
                rdPtr_d     = rdPtr_q + PTR_W'(1);
            end else begin
                holdRight_d = '0;
                underflow_d = 1'b1;
            end
        end else if (rightStart && state_q == ACTIVE) begin
            startLoad = 1'b1;
            loadWord  = holdRight_q;
        end

        if (startLoad) begin
`ifdef DAC_SERIALIZER_I2S_MODE_EN
            dacdat_d = 1'b0;
            shift_d  = loadWord;
            bitCnt_d = BIT_W'(DATA_W);
`else
            dacdat_d = loadWord[DATA_W-1];
            shift_d  = loadWord << 1;
            bitCnt_d = BIT_W'(DATA_W - 1);
`endif
        end else if (bclkFall && state_q == ACTIVE) begin
            if (bitCnt_q != '0) begin
                dacdat_d = shift_q[DATA_W-1];
                shift_d  = shift_q << 1;
                bitCnt_d = bitCnt_q - BIT_W'(1);
            end else begin
                dacdat_d = 1'b0;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lrck_q      <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            shift_q     <= '0;
            holdRight_q <= '0;
            bitCnt_q    <= '0;
            dacdat_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrck_q      <= lrck_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            holdRight_q <= holdRight_d;
            bitCnt_q    <= bitCnt_d;
            dacdat_q    <= dacdat_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_dac_serializer.sv
// Self-checking bench for dac_serializer: randomized frames compared slot-by-slot against a queue-based model.
module tb_dac_serializer;

    localparam int DW    = 24;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] wl = '0;
    logic [DW-1:0] wr = '0;
    logic          write_ready;
    logic          aud_bclk = 1'b1;
    logic          aud_daclrck = 1'b0;
    logic          aud_dacdat;
    logic          underflow;
    logic [2:0]    fifo_count;

    int testCount = 0;
    int failCount = 0;

    logic [2*DW-1:0] mq[$];
    bit              mActive = 1'b0;
    bit              mLast = 1'b0;
    bit              mUnder = 1'b0;
    logic [DW-1:0]   mHoldR = '0;

    always #5 clk = ~clk;

    dac_serializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .write           (write),
        .writedata_left  (wl),
        .writedata_right (wr),
        .write_ready     (write_ready),
        .aud_bclk        (aud_bclk),
        .aud_daclrck     (aud_daclrck),
        .aud_dacdat      (aud_dacdat),
        .underflow       (underflow),
        .fifo_count      (fifo_count)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expV);
        testCount++;
        if (obs !== expV) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expV);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mActive = 1'b0;
        mLast   = 1'b0;
        mUnder  = 1'b0;
        mHoldR  = '0;
    endtask

    // Slot-level behaviour: which word a slot carries, given the LRCK level it starts with
    task automatic modelSlot(input bit lr, output logic [DW-1:0] w);
        logic [2*DW-1:0] e;
        w = '0;
        if (lr != mLast) begin
            if (!lr) begin
                mActive = 1'b1;
                if (mq.size() > 0) begin
                    e      = mq.pop_front();
                    w      = e[2*DW-1:DW];
                    mHoldR = e[DW-1:0];
                end else begin
                    mHoldR = '0;
                    mUnder = 1'b1;
                end
            end else if (mActive) begin
                w = mHoldR;
            end
        end
        mLast = lr;
    endtask

    function automatic bit expBit(logic [DW-1:0] w, int i);
        int k;
`ifdef DAC_SERIALIZER_I2S_MODE_EN
        k = i - 1;
`else
        k = i;
`endif
        if (k < 0 || k >= DW) return 1'b0;
        return w[DW-1-k];
    endfunction

    task automatic pushPair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        @(negedge clk);
        write = 1'b1;
        wl    = l;
        wr    = r;
        checkOutput("ready", write_ready, mq.size() < DEPTH);
        if (mq.size() < DEPTH) mq.push_back({l, r});
        @(negedge clk);
        write = 1'b0;
        checkOutput("count", fifo_count, mq.size());
    endtask

    // One BCLK period of 16 clk; doPush lands in the cycle that registers a frame-start pop
    task automatic bclkCycle(input logic lr, input bit doPush, input logic [2*DW-1:0] pd, output logic sdat);
        @(negedge clk);
        aud_bclk    = 1'b0;
        aud_daclrck = lr;
        @(negedge clk);
        @(negedge clk);
        if (doPush) begin
            write = 1'b1;
            wl    = pd[2*DW-1:DW];
            wr    = pd[DW-1:0];
        end
        @(negedge clk);
        write = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        aud_bclk = 1'b1;
        sdat     = aud_dacdat;
        repeat (7) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit lr, input int len, input int resetAt,
                                 input bit doPush, input logic [2*DW-1:0] pd);
        logic [DW-1:0] w;
        logic [63:0]   obs;
        logic [63:0]   expV;
        logic          sdat;
        bit            wasReset;
        bit            accept;
        wasReset = 1'b0;
        obs      = '0;
        expV     = '0;
        accept   = doPush && (mq.size() < DEPTH);
        modelSlot(lr, w);
        if (accept) mq.push_back(pd);
        for (int i = 0; i < len; i++) begin
            bclkCycle(lr, doPush && (i == 0), pd, sdat);
            obs  = {obs[62:0], sdat};
            expV = {expV[62:0], (wasReset ? 1'b0 : expBit(w, i))};
            if (i == resetAt) begin
                @(negedge clk);
                reset = 1'b0;
                #1;
                checkOutput("rstDat", aud_dacdat, 1'b0);
                checkOutput("rstCnt", fifo_count, 3'd0);
                checkOutput("rstUnder", underflow, 1'b0);
                checkOutput("rstReady", write_ready, 1'b1);
                modelReset();
                repeat (3) @(negedge clk);
                reset    = 1'b1;
                wasReset = 1'b1;
            end
        end
        checkOutput(lr ? "slotR" : "slotL", obs, expV);
    endtask

    task automatic runFrame(input int lenL, input int lenR, input int resetAt,
                            input bit doPush, input logic [2*DW-1:0] pd);
        applyStimulus(1'b0, lenL, resetAt, doPush, pd);
        applyStimulus(1'b1, lenR, -1, 1'b0, '0);
    endtask

    initial begin
        int n;
        repeat (4) @(negedge clk);
        checkOutput("rstDat0", aud_dacdat, 1'b0);
        checkOutput("rstCnt0", fifo_count, 3'd0);
        checkOutput("rstReady0", write_ready, 1'b1);
        checkOutput("rstUnder0", underflow, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        pushPair(24'hA5A5A5, 24'h5A5A5A);
        checkOutput("under0", underflow, 1'b0);
        applyStimulus(1'b1, 32, -1, 1'b0, '0);
        runFrame(32, 32, -1, 1'b0, '0);
        checkOutput("cntAfter1", fifo_count, 3'd0);
        checkOutput("underAfter1", underflow, 1'b0);

        for (int i = 0; i < 5; i++) begin
            pushPair(DW'($urandom), DW'($urandom));
            if (i == 3) checkOutput("fullReady", write_ready, 1'b0);
        end
        checkOutput("fullCnt", fifo_count, 3'd4);
        for (int i = 0; i < 4; i++) runFrame(32, 32, -1, 1'b0, '0);
        checkOutput("drainCnt", fifo_count, 3'd0);
        checkOutput("drainUnder", underflow, 1'b0);

        runFrame(32, 32, -1, 1'b0, '0);
        runFrame(32, 32, -1, 1'b0, '0);
        checkOutput("underSet", underflow, 1'b1);

        runFrame(32, 32, -1, 1'b1, {DW'($urandom), DW'($urandom)});
        checkOutput("collideCnt", fifo_count, mq.size());
        runFrame(32, 32, -1, 1'b0, '0);
        checkOutput("collideDrain", fifo_count, mq.size());
        checkOutput("underSticky", underflow, 1'b1);

        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) pushPair(DW'($urandom), DW'($urandom));
            runFrame($urandom_range(18, 36), $urandom_range(18, 36), -1, 1'b0, '0);
            checkOutput("rndCnt", fifo_count, mq.size());
            checkOutput("rndUnder", underflow, mUnder);
        end

        while (mq.size() > 0) runFrame(32, 32, -1, 1'b0, '0);
        pushPair(24'hA5A5A5, 24'h5A5A5A);
        pushPair(DW'($urandom), DW'($urandom));
        runFrame(32, 32, 10, 1'b0, '0);
        pushPair(DW'($urandom), DW'($urandom));
        runFrame(32, 32, -1, 1'b0, '0);
        checkOutput("postRstCnt", fifo_count, mq.size());
        checkOutput("postRstUnder", underflow, mUnder);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
